// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the front end and the multiply/divide unit.
// The front end drives the issue side; the unit returns busy, stall and HI/LO.
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B,
        input  busy, stall, HI, LO
    );

    modport slave (
        input  start, op, A, B,
        output busy, stall, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Fixed busy window per operation class; result lands as busy drops.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [31:0] count, count_n;
    logic [2:0]  op_q, op_n;
    logic [31:0] a_q, a_n;
    logic [31:0] b_q, b_n;
    logic [31:0] hi, hi_n;
    logic [31:0] lo, lo_n;

    logic [63:0] res;
    logic        res_ok;
    logic [31:0] abs_a, abs_b, quo, rem;

    // Result of the latched operation; divide by zero leaves HI/LO alone
    always_comb begin
        res    = '0;
        res_ok = 1'b1;
        abs_a  = a_q[31] ? -a_q : a_q;
        abs_b  = b_q[31] ? -b_q : b_q;
        quo    = '0;
        rem    = '0;
        unique case (op_q[1:0])
            2'd0: res = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
            2'd1: res = {32'b0, a_q} * {32'b0, b_q};
            2'd2: begin
                quo    = abs_a / abs_b;
                rem    = abs_a % abs_b;
                quo    = (a_q[31] ^ b_q[31]) ? -quo : quo;
                rem    = a_q[31] ? -rem : rem;
                res    = {rem, quo};
                res_ok = |b_q;
            end
            2'd3: begin
                res    = {a_q % b_q, a_q / b_q};
                res_ok = |b_q;
            end
        endcase
    end

    // Next-state: issue/MTHI/MTLO in IDLE, countdown and writeback in RUN
    always_comb begin
        state_n = state;
        count_n = count;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = hi;
        lo_n    = lo;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.op[2]) begin
                    op_n    = bus.op;
                    a_n     = bus.A;
                    b_n     = bus.B;
                    count_n = bus.op[1] ? DIV_CYCLES : MULT_CYCLES;
                    state_n = RUN;
                end else if (bus.start && bus.op == 3'd4) begin
                    hi_n = bus.A;
                end else if (bus.start && bus.op == 3'd5) begin
                    lo_n = bus.A;
                end
            end
            RUN: begin
                count_n = count - 32'd1;
                if (count == 32'd1) begin
                    state_n = IDLE;
                    if (res_ok) begin
                        hi_n = res[63:32];
                        lo_n = res[31:0];
                    end
                end
            end
        endcase
    end

    // State and register file update; reset aborts any pending result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            op_q  <= op_n;
            a_q   <= a_n;
            b_q   <= b_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.stall = bus.busy | (bus.start & ~bus.op[2]);
    assign bus.HI    = hi;
    assign bus.LO    = lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases pinned to literals, then random
// issue traffic checked every cycle against a cycle-level arithmetic model.
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 1'b0;

    mult_div_unit_if bus ();

    mult_div_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: architectural HI/LO, cycles left in the busy window, pending result
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_left = 0;
    bit          m_pend = 0;
    longint      sa, sb, ua, ub, prod, q, r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_pend) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (bus.start) begin
            sa = {{32{bus.A[31]}}, bus.A};
            sb = {{32{bus.B[31]}}, bus.B};
            ua = {32'b0, bus.A};
            ub = {32'b0, bus.B};
            case (bus.op)
                3'd0, 3'd1: begin
                    prod   = (bus.op == 3'd0) ? sa * sb : ua * ub;
                    p_hi   = prod[63:32];
                    p_lo   = prod[31:0];
                    m_pend = 1;
                    m_left = MC;
                end
                3'd2, 3'd3: begin
                    m_pend = (bus.B != 0);
                    if (m_pend) begin
                        q = (bus.op == 3'd2) ? sa / sb : ua / ub;
                        r = (bus.op == 3'd2) ? sa % sb : ua % ub;
                        p_hi = r[31:0];
                        p_lo = q[31:0];
                    end
                    m_left = DC;
                end
                3'd4: m_hi = bus.A;
                3'd5: m_lo = bus.A;
                default: ;
            endcase
        end
    end

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("busy", 32'(bus.busy), 32'(m_left != 0));
            cmp("stall", 32'(bus.stall),
                32'((m_left != 0) || (bus.start && bus.op <= 3'd3)));
            cmp("hi", bus.HI, m_hi);
            cmp("lo", bus.LO, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'd7;
        bus.A     = '0;
        bus.B     = '0;
        #1 reset = 1'b1;
        chk_on = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        cmp("rst_busy", 32'(bus.busy), 32'd0);
        cmp("rst_hi", bus.HI, 32'd0);
        cmp("rst_lo", bus.LO, 32'd0);

        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        cmp("mult_busy0", 32'(bus.busy), 32'd1);
        repeat (MC - 1) tick();
        cmp("mult_busy4", 32'(bus.busy), 32'd1);
        cmp("mult_hold_hi", bus.HI, 32'd0);
        tick();
        cmp("mult_done", 32'(bus.busy), 32'd0);
        cmp("mult_hi", bus.HI, 32'hFFFF_FFFF);
        cmp("mult_lo", bus.LO, 32'hFFFF_FFFE);

        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        repeat (MC - 1) tick();
        cmp("multu_hold_hi", bus.HI, 32'hFFFF_FFFF);
        tick();
        cmp("multu_hi", bus.HI, 32'h0000_0001);
        cmp("multu_lo", bus.LO, 32'hFFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        repeat (DC - 1) tick();
        cmp("div_busy9", 32'(bus.busy), 32'd1);
        tick();
        cmp("div_done", 32'(bus.busy), 32'd0);
        cmp("div_lo", bus.LO, 32'hFFFF_FFFD);
        cmp("div_hi", bus.HI, 32'hFFFF_FFFF);

        issue(3'd4, 32'hAA, 32'd0);
        cmp("mthi_busy", 32'(bus.busy), 32'd0);
        cmp("mthi_hi", bus.HI, 32'hAA);
        issue(3'd5, 32'hBB, 32'd0);
        issue(3'd3, 32'h1234_5678, 32'd0);
        repeat (DC) tick();
        cmp("dz_busy", 32'(bus.busy), 32'd0);
        cmp("dz_hi", bus.HI, 32'hAA);
        cmp("dz_lo", bus.LO, 32'hBB);

        issue(3'd2, 32'd100, 32'd7);
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.A     = 32'h55;
        repeat (DC - 1) tick();
        bus.start = 1'b0;
        tick();
        cmp("busy_mthi_hi", bus.HI, 32'd2);
        cmp("busy_mthi_lo", bus.LO, 32'd14);
        issue(3'd4, 32'h55, 32'd0);
        cmp("idle_mthi_hi", bus.HI, 32'h55);
        cmp("idle_mthi_busy", 32'(bus.busy), 32'd0);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (DC) tick();
        cmp("ovf_lo", bus.LO, 32'h8000_0000);
        cmp("ovf_hi", bus.HI, 32'h0);

        issue(3'd0, 32'd3, 32'd4);
        repeat (MC) tick();
        cmp("b2b_lo1", bus.LO, 32'd12);
        issue(3'd1, 32'd5, 32'd6);
        cmp("b2b_busy", 32'(bus.busy), 32'd1);
        repeat (MC) tick();
        cmp("b2b_lo2", bus.LO, 32'd30);

        issue(3'd0, 32'd7, 32'd9);
        tick();
        #2 reset = 1'b1;
        #1;
        cmp("abort_busy", 32'(bus.busy), 32'd0);
        cmp("abort_hi", bus.HI, 32'd0);
        cmp("abort_lo", bus.LO, 32'd0);
        tick();
        reset = 1'b0;
        repeat (MC + 3) tick();
        cmp("abort_late_lo", bus.LO, 32'd0);

        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom % 3) != 0;
            bus.op    = 3'($urandom % 8);
            bus.A     = pick();
            bus.B     = pick();
            tick();
        end
        bus.start = 1'b0;
        repeat (DC + 2) tick();

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
